mem_bist_ctrl: RTL and testbench

Built-in self-test master that sits directly upstream of the static valid/ready memory and drives its request port. On `start` it writes a programmable address-derived pattern over a contiguous window of words, then reads the same window back. It compares every read word against the expected pattern and reports pass/fail, an error count, and the first failing address. It also guards each handshake with a timeout so a dead memory cannot hang the test.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_pattern_gen.sv | 24 ++
 rtl/mem_bist_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the static memory, its BIST master and their benches.
package mem_pkg;

  localparam int MEM_DEPTH      = 1024;
  localparam int MEM_WIDTH      = 32;
  localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);

  localparam logic [1:0] MODE_ADDR = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_CHK  = 2'd2;
  localparam logic [1:0] MODE_ONES = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_DONE
  } bist_state_t;

endpackage

// File: rtl/mem_pattern_gen.sv
// Address-derived BIST data pattern; purely combinational.
module mem_pattern_gen
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      data
);

  always_comb begin
    data = '1;
    case (mode)
      MODE_ADDR: data = WIDTH'(addr);
      MODE_INV:  data = ~(WIDTH'(addr));
      MODE_CHK:  data = addr[0] ? {(WIDTH/2){2'b01}} : {(WIDTH/2){2'b10}};
      MODE_ONES: data = '1;
      default:   data = '1;
    endcase
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// BIST master: writes a pattern over an address window, reads it back and
// reports mismatches, first failing address and handshake timeouts.
module mem_bist_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH      = MEM_DEPTH,
  parameter int WIDTH      = MEM_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ERRW       = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic                  ready,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ERRW-1:0]       err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  bist_state_t           state;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] start_addr_q;
  logic [ADDR_WIDTH:0]   nwords_q;
  logic [ADDR_WIDTH:0]   idx;
  logic [TW-1:0]         wait_cnt;

  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  last_beat;
  logic                  wait_expired;
  logic [1:0]            gen_mode;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [WIDTH-1:0]      gen_data;
  logic [WIDTH-1:0]      exp_data;
  logic                  mismatch;

  always_comb begin
    addr_inc     = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    last_beat    = (idx == nwords_q - 1'b1);
    wait_expired = (wait_cnt == TW'(TIMEOUT - 1));
    gen_mode     = (state == ST_IDLE) ? mode : mode_q;
    gen_addr     = (state == ST_IDLE) ? start_addr : addr_inc;
    mismatch     = (rdata != exp_data);
  end

  // One instance produces the next write word, the other the word expected
  // for the read currently outstanding at the held address.
  mem_pattern_gen #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_pat (
    .mode (gen_mode),
    .addr (gen_addr),
    .data (gen_data)
  );

  mem_pattern_gen #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_pat (
    .mode (mode_q),
    .addr (addr),
    .data (exp_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      mode_q         <= '0;
      start_addr_q   <= '0;
      nwords_q       <= '0;
      idx            <= '0;
      wait_cnt       <= '0;
      valid          <= 1'b0;
      wr_rd          <= 1'b0;
      addr           <= '0;
      wdata          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q         <= mode;
            start_addr_q   <= start_addr;
            nwords_q       <= num_words;
            idx            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            busy           <= 1'b1;
            if (num_words == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= ST_WR_ISSUE;
              valid <= 1'b1;
              wr_rd <= 1'b1;
              addr  <= start_addr;
              wdata <= gen_data;
            end
          end
        end
        ST_WR_ISSUE: begin
          state    <= ST_WR_WAIT;
          wait_cnt <= '0;
        end
        ST_RD_ISSUE: begin
          state    <= ST_RD_WAIT;
          wait_cnt <= '0;
        end
        ST_WR_WAIT: begin
          if (ready) begin
            valid <= 1'b1;
            if (last_beat) begin
              idx   <= '0;
              state <= ST_RD_ISSUE;
              wr_rd <= 1'b0;
              addr  <= start_addr_q;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_WR_ISSUE;
              addr  <= addr_inc;
              wdata <= gen_data;
            end
          end else if (wait_expired) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (ready) begin
            if (mismatch) begin
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (err_count == '0) first_err_addr <= addr;
            end
            if (last_beat) begin
              state <= ST_DONE;
              done  <= 1'b1;
              // Include the final comparison, which lands in this same edge.
              pass  <= !mismatch && (err_count == '0);
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_RD_ISSUE;
              valid <= 1'b1;
              addr  <= addr_inc;
            end
          end else if (wait_expired) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl against a behavioural memory and a
// window/pattern reference model.
module tb_mem_bist_ctrl;

  localparam int DEPTH   = 1024;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [9:0]  start_addr;
  logic [10:0] num_words;
  logic        valid;
  logic        wr_rd;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] err_count;
  logic [9:0]  first_err_addr;

  bit          stall_en;
  bit          fault_en;
  logic [9:0]  fault_addr;
  logic [31:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  mem_bist_ctrl #(
    .DEPTH   (DEPTH),
    .WIDTH   (32),
    .ERRW    (16),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .start_addr     (start_addr),
    .num_words      (num_words),
    .valid          (valid),
    .wr_rd          (wr_rd),
    .addr           (addr),
    .wdata          (wdata),
    .ready          (ready),
    .rdata          (rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  // Memory with a one-cycle registered acknowledge; optional stall and stuck-at-0 read.
  always @(posedge clk) begin
    ready <= 1'b0;
    if (valid && !stall_en) begin
      ready <= 1'b1;
      if (wr_rd) mem[addr] <= wdata;
      else rdata <= (fault_en && addr == fault_addr) ? 32'h0 : mem[addr];
    end
  end

  function automatic logic [31:0] pat(input int m, input int a);
    logic [31:0] av;
    av = 32'(a);
    case (m)
      0:       return av;
      1:       return ~av;
      2:       return (a % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic run_bist(input int m, input int sa, input int n, input bit fault,
                          input int faddr, input bit stall, input int poke);
    int cyc, budget, done_cyc, nbeats, bad_beats, dbl;
    int exp_done, exp_beats, exp_err, exp_first, ea, bad_a;
    bit exp_to, exp_pass, prev_v, busy_bad, ew;
    logic [31:0] ed;
    fault_en   = fault;
    fault_addr = 10'(faddr);
    stall_en   = stall;
    @(negedge clk);
    mode = 2'(m); start_addr = 10'(sa); num_words = 11'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; done_cyc = -1; nbeats = 0; bad_beats = 0; dbl = 0; bad_a = -1;
    prev_v = 1'b0; busy_bad = 1'b0;
    budget = 4 * n + TIMEOUT + 10;
    while (cyc <= budget) begin
      if (cyc == poke) begin
        start = 1'b1; mode = ~mode; start_addr = start_addr + 10'd77; num_words = 11'd1;
      end else begin
        start = 1'b0;
      end
      if (valid) begin
        if (prev_v) dbl++;
        if (nbeats < n) begin
          ea = (sa + nbeats) % DEPTH; ew = 1'b1; ed = pat(m, ea);
        end else begin
          ea = (sa + nbeats - n) % DEPTH; ew = 1'b0; ed = wdata;
        end
        if (addr !== 10'(ea) || wr_rd !== ew || wdata !== ed) begin
          bad_beats++;
          if (bad_a < 0) bad_a = ea;
        end
        nbeats++;
      end
      prev_v = valid;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    exp_to    = stall && (n > 0);
    exp_done  = exp_to ? TIMEOUT + 2 : 4 * n + 1;
    exp_beats = exp_to ? 1 : 2 * n;
    exp_err   = 0;
    if (!stall && fault)
      for (int k = 0; k < n; k++)
        if ((sa + k) % DEPTH == faddr && pat(m, faddr) != 0) exp_err++;
    exp_first = (exp_err > 0) ? faddr : 0;
    exp_pass  = !exp_to && exp_err == 0;

    checks++;
    if (done_cyc != exp_done) begin
      errors++;
      $display("FAIL done_cycle m=%0d sa=%0d n=%0d: got %0d want %0d", m, sa, n, done_cyc, exp_done);
    end
    checks++;
    if (nbeats != exp_beats) begin
      errors++;
      $display("FAIL beat_count m=%0d sa=%0d n=%0d: got %0d want %0d", m, sa, n, nbeats, exp_beats);
    end
    checks++;
    if (bad_beats != 0) begin
      errors++;
      $display("FAIL beat_content m=%0d sa=%0d n=%0d: %0d bad beats, first expected addr %0d, want 0 bad",
               m, sa, n, bad_beats, bad_a);
    end
    checks++;
    if (dbl != 0 || busy_bad) begin
      errors++;
      $display("FAIL handshake_busy: back-to-back valid %0d busy_drop %0d, want 0 0", dbl, busy_bad);
    end
    checks++;
    if (pass !== exp_pass || timeout !== exp_to) begin
      errors++;
      $display("FAIL pass_timeout m=%0d sa=%0d n=%0d: got pass=%b to=%b want pass=%b to=%b",
               m, sa, n, pass, timeout, exp_pass, exp_to);
    end
    checks++;
    if (err_count !== 16'(exp_err) || first_err_addr !== 10'(exp_first)) begin
      errors++;
      $display("FAIL err_report m=%0d sa=%0d n=%0d: got cnt=%0d first=%0d want cnt=%0d first=%0d",
               m, sa, n, err_count, first_err_addr, exp_err, exp_first);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_pass) begin
      errors++;
      $display("FAIL post_done: got done=%b busy=%b pass=%b want 0 0 %b", done, busy, pass, exp_pass);
    end
    stall_en = 1'b0;
    fault_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = '0; start_addr = '0; num_words = '0;
    stall_en = 1'b0; fault_en = 1'b0; fault_addr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, wr_rd, addr, wdata, busy, done, pass, timeout, err_count, first_err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b wr_rd=%b addr=%0d wdata=%h busy=%b done=%b pass=%b to=%b cnt=%0d first=%0d want all 0",
               valid, wr_rd, addr, wdata, busy, done, pass, timeout, err_count, first_err_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    run_bist(0, 0, 4, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_wrap_mode2();
    run_bist(2, DEPTH - 1, 2, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_fault();
    run_bist(1, 4, 4, 1'b1, 5, 1'b0, -1);
  endtask

  task automatic test_timeout();
    run_bist(3, 100, 3, 1'b0, 0, 1'b1, -1);
  endtask

  task automatic test_zero_len();
    run_bist(0, 17, 0, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_busy_start();
    run_bist(2, 50, 4, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_reset_mid();
    int ndone, nvalid;
    @(negedge clk);
    mode = 2'd0; start_addr = 10'd200; num_words = 11'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({valid, wr_rd, addr, wdata, busy, done, pass, timeout, err_count, first_err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got valid=%b busy=%b addr=%0d wdata=%h done=%b want all 0",
               valid, busy, addr, wdata, done);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0; nvalid = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) ndone++;
      if (valid) nvalid++;
    end
    checks++;
    if (ndone != 0 || nvalid != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got done=%0d valid=%0d pulses want 0 0", ndone, nvalid);
    end
  endtask

  task automatic test_random();
    int m, sa, n, fa;
    bit fault;
    for (int t = 0; t < 25; t++) begin
      m     = int'($urandom_range(0, 3));
      sa    = int'($urandom_range(0, DEPTH - 1));
      n     = int'($urandom_range(0, 12));
      fault = ($urandom_range(0, 1) == 1);
      fa    = (sa + int'($urandom_range(0, 14))) % DEPTH;
      run_bist(m, sa, n, fault, fa, ($urandom_range(0, 9) == 0), -1);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_wrap_mode2();
    test_fault();
    test_timeout();
    test_zero_len();
    test_busy_start();
    test_reset_mid();
    test_mode0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
